irq_ack_dec: RTL and testbench
==============================

# irq_ack_dec

CPU-side interrupt acknowledge decoder: the receiving end of the 4-source priority vector encoder. It latches the peripheral `done[3:0]` requests into pending bits and raises `irq` to the core. It decodes the vector address the core acknowledges back to a source index, pulses a one-hot clear to that peripheral, and tracks the in-service source until end-of-interrupt. It sits between the peripheral `done` lines and the core's exception entry and return logic.

## Interface
- `ACK_TIMEOUT`, 255: cycles `irq` may stay unacknowledged before a drop-and-retry. Used only with `IRQ_TIMEOUT_EN`; range 1..255, 8-bit counter.

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `done`, in, 4: level requests from peripherals; bit 0 has the highest priority.
- `ack`, in, 1: core acknowledges `irq`; `ack_addr` is valid in the same cycle.
- `ack_addr`, in, 32: vector address being serviced.
- `eoi`, in, 1: core end-of-interrupt (return from handler).
- `irq`, out, 1: interrupt request to the core, registered.
- `clr`, out, 4: one-cycle, one-hot clear pulse to the serviced peripheral.
- `active`, out, 4: one-hot in-service source; 0 when none is in service.
- `bad_vec`, out, 1: one-cycle pulse when an acknowledge fails to decode.
- `timeout`, out, 1: one-cycle pulse on acknowledge timeout; constant 0 without the macro.

## Operation
- Vector map (fixed): source 0 = 0x0000002C, source 1 = 0x00000004, source 2 = 0x00000008, source 3 = 0x0000000C. Comparison is on all 32 bits.
- `pending[3:0]` register:
  - Any cycle with `done[i]=1` sets `pending[i]`.
  - A successful acknowledge of source i clears `pending[i]`.
  - If set and clear hit the same bit in the same cycle, set wins: the bit stays 1 and `clr[i]` still pulses.
- FSM states: IDLE, REQ, SVC.
- IDLE:
  - `irq=0`.
  - If `pending!=0` → REQ.
  - `ack` and `eoi` are ignored.
- REQ:
  - `irq=1`.
  - On `ack` with `ack_addr` decoding to source i and `pending[i]=1`:
    - clear `pending[i]`, `clr[i]=1` for one cycle;
    - `active` ← one-hot(i);
    - → SVC.
  - On `ack` with an unmapped address, or with a mapped address whose pending bit is 0:
    - `bad_vec=1` for one cycle;
    - stay in REQ; `pending` and `active` unchanged.
  - `eoi` is ignored.
- SVC:
  - `irq=0`.
  - On `eoi`: `active` ← 0, → IDLE.
  - `ack` is ignored.
  - New `done` pulses still latch into `pending`.
- Priority is not enforced here. The core acknowledges whatever vector the encoder presented, and any pending source is accepted.
- Reset:
  - Forces IDLE, `pending=0`, and `irq`, `clr`, `active`, `bad_vec`, `timeout` all 0, plus the timeout counter to 0.
  - Reset overrides `done`, `ack` and `eoi` in the same cycle.
  - A mid-service reset drops `active` without a `clr` pulse.

## Timing
- All outputs are registered.
- `done[i]` high in cycle N → `pending[i]` set at edge N+1 → `irq=1` from cycle N+2.
- `ack` in cycle M (valid):
  - `clr`, `active` and state SVC appear in cycle M+1;
  - `irq=0` in cycle M+1.
- `ack` in cycle M (invalid): `bad_vec=1` in cycle M+1 only; `irq` stays 1.
- `eoi` in cycle K:
  - `active=0` and IDLE in cycle K+1;
  - if other bits are pending, `irq=1` again in cycle K+2.
- `clr`, `bad_vec` and `timeout` are exactly one cycle wide.
- Back-to-back `ack` while in REQ: each is evaluated independently.

## Configuration
- Macro: `IRQ_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears to 0 on entry to REQ and increments each REQ cycle with `ack=0`.
  - When it equals `ACK_TIMEOUT`, the next cycle has `timeout=1`, state IDLE and `irq=0`, with `pending` retained.
  - `irq` re-asserts one cycle later.
  - An `ack` in the terminal cycle wins over the timeout.
- Undefined: no counter; REQ waits indefinitely; `timeout` is tied to 0.

## Test plan
1. Valid acknowledge of source 2:
   - Stimulus: `done=4'b0100` for 1 cycle, then `ack=1`, `ack_addr=0x00000008` two cycles later.
   - Required: `irq` rises at N+2, then `clr=4'b0100` for 1 cycle, `active=4'b0100`, `irq=0`.
   - Then `eoi` → `active=0`.
2. Two pending sources:
   - Stimulus: `done=4'b0011`; ack 0x2C; `eoi`.
   - Required: `irq` re-asserts 2 cycles after `eoi`.
   - Then ack 0x04 → `clr=4'b0010`; `pending=0` after.
3. Bad acknowledge:
   - Stimulus: ack with `ack_addr=0x00000010`, then ack 0x0C while `pending[3]=0`.
   - Required: `bad_vec` pulses twice; `irq` stays 1; `pending` unchanged.
4. Set and clear collide: `done[0]=1` in the same cycle as a valid ack of 0x2C → `clr[0]` pulses and `pending[0]` stays 1.
5. Reset mid-service: `rst` asserted in SVC with `active=4'b1000` → next cycle all outputs are 0 and state is IDLE.
6. Timeout (with `IRQ_TIMEOUT_EN`, `ACK_TIMEOUT=4`): no ack for 4 REQ cycles → `timeout=1` and `irq=0` for 1 cycle, then `irq=1` again with `pending` intact.

Source files
------------

// File: rtl/irq_ack_if.sv
// irq_ack_if: bundles the decoder's request/acknowledge signals.
//   master : peripheral/core side, drives done, ack, ack_addr, eoi
//   slave  : irq_ack_dec, drives irq, clr, active, bad_vec, timeout
interface irq_ack_if;
    logic [3:0]  done;
    logic        ack;
    logic [31:0] ack_addr;
    logic        eoi;
    logic        irq;
    logic [3:0]  clr;
    logic [3:0]  active;
    logic        bad_vec;
    logic        timeout;

    modport master (
        output done, ack, ack_addr, eoi,
        input  irq, clr, active, bad_vec, timeout
    );

    modport slave (
        input  done, ack, ack_addr, eoi,
        output irq, clr, active, bad_vec, timeout
    );
endinterface

// File: rtl/irq_ack_dec.sv
// irq_ack_dec: CPU-side interrupt acknowledge decoder.
// Latches peripheral done requests into pending bits, raises irq, decodes the
// acknowledged vector address back to a source, pulses a one-hot clear to that
// source and tracks it as in-service until end-of-interrupt.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - irq_ack_if.slave: done[3:0], ack, ack_addr[31:0], eoi in;
//          irq, clr[3:0], active[3:0], bad_vec, timeout out (all registered)
// Parameter:
//   ACK_TIMEOUT - unacknowledged REQ cycles before drop-and-retry (1..255)
// Build option:
//   IRQ_TIMEOUT_EN - when defined, enables the acknowledge timeout; otherwise
//                    REQ waits forever and timeout is tied low.
module irq_ack_dec #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst,
    irq_ack_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t     state;
    logic [3:0] pending;
    logic       irq_q;
    logic [3:0] clr_q;
    logic [3:0] active_q;
    logic       bad_vec_q;

    // Fixed vector map, full 32-bit compare.
    logic       dec_hit;
    logic [3:0] dec_oh;
    always_comb begin
        dec_hit = 1'b1;
        dec_oh  = 4'b0000;
        case (bus.ack_addr)
            32'h0000_002C: dec_oh = 4'b0001;
            32'h0000_0004: dec_oh = 4'b0010;
            32'h0000_0008: dec_oh = 4'b0100;
            32'h0000_000C: dec_oh = 4'b1000;
            default:       dec_hit = 1'b0;
        endcase
    end

    // An acknowledge only succeeds for a mapped source that is actually pending.
    logic       ack_ok;
    logic [3:0] clr_mask;
    always_comb begin
        ack_ok   = (state == REQ) && bus.ack && dec_hit && ((dec_oh & pending) != 4'b0000);
        clr_mask = ack_ok ? dec_oh : 4'b0000;
    end

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(ACK_TIMEOUT);
    logic [7:0] to_cnt;
    logic       timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 4'b0000;
            irq_q     <= 1'b0;
            clr_q     <= 4'b0000;
            active_q  <= 4'b0000;
            bad_vec_q <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            to_cnt    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            clr_q     <= clr_mask;
            bad_vec_q <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            // New requests are OR'd in after the clear, so a same-cycle
            // set wins while clr still pulses.
            pending   <= (pending & ~clr_mask) | bus.done;

            case (state)
                IDLE: begin
                    if (pending != 4'b0000) begin
                        state <= REQ;
                        irq_q <= 1'b1;
`ifdef IRQ_TIMEOUT_EN
                        to_cnt <= 8'd0;
`endif
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        if (ack_ok) begin
                            state    <= SVC;
                            irq_q    <= 1'b0;
                            active_q <= dec_oh;
                        end else begin
                            bad_vec_q <= 1'b1;
                        end
                    end
`ifdef IRQ_TIMEOUT_EN
                    // Fires on the cycle whose increment would reach the limit.
                    else if (to_cnt + 8'd1 == TO_LIM) begin
                        state     <= IDLE;
                        irq_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        to_cnt    <= 8'd0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                SVC: begin
                    if (bus.eoi) begin
                        state    <= IDLE;
                        active_q <= 4'b0000;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq     = irq_q;
    assign bus.clr     = clr_q;
    assign bus.active  = active_q;
    assign bus.bad_vec = bad_vec_q;
`ifdef IRQ_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ack_dec.sv
module tb_irq_ack_dec;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    irq_ack_if bus ();

    irq_ack_dec #(.ACK_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_ack(input logic a, input logic [31:0] addr);
        bus.ack      = a;
        bus.ack_addr = addr;
    endtask

    initial begin
        rst          = 1'b1;
        bus.done     = 4'b0000;
        bus.ack      = 1'b0;
        bus.ack_addr = 32'h0;
        bus.eoi      = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_clr", 32'(bus.clr), 32'h0);
        chk("rst_active", 32'(bus.active), 32'h0);
        chk("rst_bad", 32'(bus.bad_vec), 32'h0);
        chk("rst_to", 32'(bus.timeout), 32'h0);
        chk("rst_pend", 32'(dut.pending), 32'h0);
        rst = 1'b0;

        // 1: valid acknowledge of source 2
        bus.done = 4'b0100; tick(); bus.done = 4'b0000;
        chk("t1_irq_n1", 32'(bus.irq), 32'h0);
        chk("t1_pend", 32'(dut.pending), 32'h4);
        tick();
        chk("t1_irq_n2", 32'(bus.irq), 32'h1);
        set_ack(1'b1, 32'h8); tick(); set_ack(1'b0, 32'h0);
        chk("t1_clr", 32'(bus.clr), 32'h4);
        chk("t1_active", 32'(bus.active), 32'h4);
        chk("t1_irq_svc", 32'(bus.irq), 32'h0);
        chk("t1_pend_clr", 32'(dut.pending), 32'h0);
        tick();
        chk("t1_clr_1cyc", 32'(bus.clr), 32'h0);
        chk("t1_active_hold", 32'(bus.active), 32'h4);
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        chk("t1_eoi_active", 32'(bus.active), 32'h0);
        tick();
        chk("t1_idle_irq", 32'(bus.irq), 32'h0);

        // 2: two pending sources
        bus.done = 4'b0011; tick(); bus.done = 4'b0000;
        chk("t2_pend", 32'(dut.pending), 32'h3);
        tick();
        chk("t2_irq", 32'(bus.irq), 32'h1);
        set_ack(1'b1, 32'h2C); tick(); set_ack(1'b0, 32'h0);
        chk("t2_clr0", 32'(bus.clr), 32'h1);
        chk("t2_active0", 32'(bus.active), 32'h1);
        chk("t2_pend1", 32'(dut.pending), 32'h2);
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        chk("t2_eoi_active", 32'(bus.active), 32'h0);
        chk("t2_eoi_irq_k1", 32'(bus.irq), 32'h0);
        tick();
        chk("t2_irq_k2", 32'(bus.irq), 32'h1);
        set_ack(1'b1, 32'h4); tick(); set_ack(1'b0, 32'h0);
        chk("t2_clr1", 32'(bus.clr), 32'h2);
        chk("t2_active1", 32'(bus.active), 32'h2);
        chk("t2_pend_empty", 32'(dut.pending), 32'h0);
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        tick();

        // 3: bad acknowledges, back to back
        bus.done = 4'b0001; tick(); bus.done = 4'b0000;
        tick();
        chk("t3_irq", 32'(bus.irq), 32'h1);
        set_ack(1'b1, 32'h10); tick();
        chk("t3_bad1", 32'(bus.bad_vec), 32'h1);
        chk("t3_irq1", 32'(bus.irq), 32'h1);
        chk("t3_pend1", 32'(dut.pending), 32'h1);
        chk("t3_clr1", 32'(bus.clr), 32'h0);
        set_ack(1'b1, 32'hC); tick(); set_ack(1'b0, 32'h0);
        chk("t3_bad2", 32'(bus.bad_vec), 32'h1);
        chk("t3_irq2", 32'(bus.irq), 32'h1);
        chk("t3_pend2", 32'(dut.pending), 32'h1);
        chk("t3_active", 32'(bus.active), 32'h0);
        tick();
        chk("t3_bad_1cyc", 32'(bus.bad_vec), 32'h0);

        // 4: set and clear collide on source 0
        set_ack(1'b1, 32'h2C); bus.done = 4'b0001; tick();
        set_ack(1'b0, 32'h0); bus.done = 4'b0000;
        chk("t4_clr", 32'(bus.clr), 32'h1);
        chk("t4_pend_kept", 32'(dut.pending), 32'h1);
        chk("t4_active", 32'(bus.active), 32'h1);
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        tick();
        chk("t4_reirq", 32'(bus.irq), 32'h1);
        set_ack(1'b1, 32'h2C); tick(); set_ack(1'b0, 32'h0);
        chk("t4_pend_gone", 32'(dut.pending), 32'h0);

        // 5: reset mid-service with source 3 active
        bus.done = 4'b1000; tick(); bus.done = 4'b0000;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        tick();
        chk("t5_irq", 32'(bus.irq), 32'h1);
        set_ack(1'b1, 32'hC); tick(); set_ack(1'b0, 32'h0);
        chk("t5_active", 32'(bus.active), 32'h8);
        rst = 1'b1; bus.done = 4'b0010; tick();
        rst = 1'b0; bus.done = 4'b0000;
        chk("t5_active_rst", 32'(bus.active), 32'h0);
        chk("t5_clr_rst", 32'(bus.clr), 32'h0);
        chk("t5_irq_rst", 32'(bus.irq), 32'h0);
        chk("t5_pend_rst", 32'(dut.pending), 32'h0);
        tick();
        chk("t5_idle", 32'(bus.irq), 32'h0);

        // 6: acknowledge timeout
        bus.done = 4'b0100; tick(); bus.done = 4'b0000;
        tick();
        chk("t6_irq", 32'(bus.irq), 32'h1);
        tick(); tick(); tick(); tick();
`ifdef IRQ_TIMEOUT_EN
        chk("t6_timeout", 32'(bus.timeout), 32'h1);
        chk("t6_irq_drop", 32'(bus.irq), 32'h0);
        chk("t6_pend", 32'(dut.pending), 32'h4);
        tick();
        chk("t6_timeout_1cyc", 32'(bus.timeout), 32'h0);
        chk("t6_irq_back", 32'(bus.irq), 32'h1);
`else
        chk("t6_no_timeout", 32'(bus.timeout), 32'h0);
        chk("t6_irq_held", 32'(bus.irq), 32'h1);
        chk("t6_pend", 32'(dut.pending), 32'h4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
